// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus
//   req/addr : fetch request and word address, driven by the fetch unit
//   ready    : response valid for the current request, driven by memory
//   rdata    : instruction word, valid with ready
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;
    modport master (output req, addr, input ready, rdata);
    modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end owning the PC and the IF/ID register
//   clk, rst         : clock, asynchronous active-high reset
//   imem             : instruction-memory bus (master side)
//   stall            : decode cannot accept, hold IF/ID
//   redirect, redirect_pc : taken branch, flush and refetch from target
//   if_valid, if_pc4, if_instr : IF/ID register contents
//   fetch_busy       : a request is on the bus (REQ or DRAIN)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master imem,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc4,
    output logic [31:0] if_instr,
    output logic        fetch_busy
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, FULL} state_t;
    state_t state, state_nx;
    logic [31:0] pc, tgt, pc4, rpc, skid_instr, skid_pc4;
    logic xfer, load, skid_load;
    assign pc4 = pc + 32'd4;
    assign rpc = redirect_pc & 32'hFFFF_FFFC;
    assign xfer = imem.req && imem.ready;
    // an empty IF/ID slot is always fillable, even under stall
    assign load = state == REQ && xfer && (!stall || !if_valid);
    assign skid_load = state == REQ && xfer && stall && if_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // a redirect with no completion must let the pending request finish first
    always_comb begin
        state_nx = state == IDLE  ? REQ :
                   state == REQ   ? (redirect ? (xfer ? REQ : DRAIN) : (skid_load ? FULL : REQ)) :
                   state == DRAIN ? (!redirect && xfer ? REQ : DRAIN) :
                                    (redirect || !stall ? REQ : FULL);
    end
    always_comb begin
        imem.req   = state == REQ || state == DRAIN;
        imem.addr  = pc & 32'hFFFF_FFFC;
        fetch_busy = state == REQ || state == DRAIN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            tgt        <= '0;
            skid_instr <= '0;
            skid_pc4   <= '0;
            if_valid   <= 1'b0;
            if_pc4     <= '0;
            if_instr   <= '0;
        end else if (redirect) begin
            if_valid <= 1'b0;
            // keep the address stable while a request is still pending
            if (state == DRAIN || (state == REQ && !xfer)) tgt <= rpc;
            else                                           pc  <= rpc;
        end else begin
            if (load) begin
                if_valid <= 1'b1;
                if_instr <= imem.rdata;
                if_pc4   <= pc4;
            end else if (state == FULL && !stall) begin
                if_valid <= 1'b1;
                if_instr <= skid_instr;
                if_pc4   <= skid_pc4;
            end else if (!stall) begin
                if_valid <= 1'b0;
            end
            if (skid_load) begin
                skid_instr <= imem.rdata;
                skid_pc4   <= pc4;
            end
            if (state == REQ && xfer)   pc <= pc4;
            if (state == DRAIN && xfer) pc <= tgt;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic        fetch_busy;
    int n_tests = 0;
    int n_fail = 0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
        .clk(clk),
        .rst(rst),
        .imem(bus),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .if_valid(if_valid),
        .if_pc4(if_pc4),
        .if_instr(if_instr),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rp,
                         input logic rdy, input logic [31:0] data);
        stall = st;
        redirect = rd;
        redirect_pc = rp;
        bus.ready = rdy;
        bus.rdata = data;
    endtask

    logic [31:0] exp_pc, p_pc4, p_instr, p_addr;
    logic        p_valid, p_req;
    int          consumed;

    initial begin
        bus.ready = 1'b0;
        bus.rdata = '0;
        tick;
        tick;
        chk("rst_req", bus.req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_pc4", if_pc4, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_addr", bus.addr, 32'h40);
        chk("rst_busy", fetch_busy, 0);
        rst = 1'b0;
        // redirect from IDLE to 0 so the straight-line run starts at address 0
        drive(0, 1, 32'h0, 0, 0);
        tick;
        chk("idle_redir_req", bus.req, 1);
        chk("idle_redir_addr", bus.addr, 0);
        for (int i = 0; i < 6; i++) begin
            chk("line_addr", bus.addr, 4 * i);
            drive(0, 0, 0, 1, mem(4 * i));
            tick;
            chk("line_valid", if_valid, 1);
            chk("line_pc4", if_pc4, 4 * i + 4);
            chk("line_instr", if_instr, mem(4 * i));
        end
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                chk("lat_addr", bus.addr, 24 + 4 * k);
                chk("lat_busy", fetch_busy, 1);
                drive(0, 0, 0, c == 2, mem(24 + 4 * k));
                tick;
                chk("lat_valid", if_valid, c == 2);
            end
        end
        chk("lat_pc4", if_pc4, 36);
        // redirect coincident with completion: word dropped, new address next cycle
        drive(0, 1, 32'h10, 1, mem(36));
        tick;
        chk("redir_ready_valid", if_valid, 0);
        chk("redir_ready_addr", bus.addr, 32'h10);
        drive(1, 0, 0, 1, mem(32'h10));
        tick;
        chk("stall_load_empty", if_pc4, 32'h14);
        drive(1, 0, 0, 1, mem(32'h14));
        tick;
        for (int c = 0; c < 3; c++) begin
            chk("stall_pc4", if_pc4, 32'h14);
            chk("stall_instr", if_instr, mem(32'h10));
            chk("stall_valid", if_valid, 1);
            chk("full_req", bus.req, 0);
            chk("full_busy", fetch_busy, 0);
            drive(1, 0, 0, 1, 32'hBAD0_BAD0);
            if (c < 2) tick;
        end
        drive(0, 0, 0, 0, 0);
        tick;
        chk("skid_pc4", if_pc4, 32'h18);
        chk("skid_instr", if_instr, mem(32'h14));
        chk("skid_valid", if_valid, 1);
        chk("skid_next_addr", bus.addr, 32'h18);
        chk("skid_next_req", bus.req, 1);
        drive(0, 0, 0, 1, mem(32'h18));
        tick;
        chk("after_skid_pc4", if_pc4, 32'h1C);
        drive(0, 0, 0, 1, mem(32'h1C));
        tick;
        drive(0, 0, 0, 0, 0);
        tick;
        chk("pend_addr", bus.addr, 32'h20);
        drive(0, 1, 32'h100, 0, 0);
        tick;
        chk("drain_valid", if_valid, 0);
        chk("drain_addr", bus.addr, 32'h20);
        chk("drain_busy", fetch_busy, 1);
        drive(0, 0, 0, 0, 0);
        tick;
        chk("drain_addr2", bus.addr, 32'h20);
        drive(0, 0, 0, 1, 32'hDEAD_BEEF);
        tick;
        chk("drained_valid", if_valid, 0);
        chk("drained_instr", if_instr, mem(32'h1C));
        chk("drained_addr", bus.addr, 32'h100);
        drive(0, 0, 0, 1, mem(32'h100));
        tick;
        chk("tgt_pc4", if_pc4, 32'h104);
        chk("tgt_instr", if_instr, mem(32'h100));
        drive(1, 1, 32'h203, 1, mem(32'h104));
        tick;
        chk("redir_stall_valid", if_valid, 0);
        chk("redir_stall_addr", bus.addr, 32'h200);
        chk("redir_stall_req", bus.req, 1);
        drive(0, 0, 0, 1, mem(32'h200));
        tick;
        chk("redir_stall_pc4", if_pc4, 32'h204);
        chk("redir_stall_instr", if_instr, mem(32'h200));
        drive(0, 1, 32'h300, 0, 0);
        tick;
        chk("pre_areset_busy", fetch_busy, 1);
        rst = 1'b1;
        #1;
        chk("areset_req", bus.req, 0);
        chk("areset_valid", if_valid, 0);
        chk("areset_addr", bus.addr, 32'h40);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 1, 32'hBAD0_BAD0);
        tick;
        chk("late_ready_valid", if_valid, 0);
        chk("late_ready_addr", bus.addr, 32'h40);
        chk("late_ready_req", bus.req, 1);
        drive(0, 0, 0, 1, mem(32'h40));
        tick;
        chk("resume_pc4", if_pc4, 32'h44);
        drive(0, 1, 32'hFFFF_FFFC, 1, mem(32'h44));
        tick;
        chk("wrap_addr0", bus.addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, mem(32'hFFFF_FFFC));
        tick;
        chk("wrap_pc4", if_pc4, 0);
        chk("wrap_addr", bus.addr, 0);
        // random phase: instruction stream must be consecutive from each restart point
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_pc = 32'h40;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            p_valid = if_valid;
            p_pc4 = if_pc4;
            p_instr = if_instr;
            p_req = bus.req;
            p_addr = bus.addr;
            stall = $urandom_range(0, 9) < 3;
            redirect = $urandom_range(0, 19) == 0;
            redirect_pc = $urandom;
            bus.ready = p_req ? $urandom_range(0, 2) == 0 : $urandom_range(0, 4) == 0;
            bus.rdata = p_req ? mem(p_addr) : 32'hBAD0_BAD0;
            if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (p_valid && !stall) begin
                chk("rnd_pc4", p_pc4, exp_pc + 32'd4);
                chk("rnd_instr", p_instr, mem(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            tick;
            if (redirect) begin
                chk("rnd_flush", if_valid, 0);
            end else if (p_valid && stall) begin
                chk("rnd_hold_valid", if_valid, 1);
                chk("rnd_hold_pc4", if_pc4, p_pc4);
                chk("rnd_hold_instr", if_instr, p_instr);
            end
            if (p_req && !bus.ready) begin
                chk("rnd_req_hold", bus.req, 1);
                chk("rnd_addr_hold", bus.addr, p_addr);
            end
        end
        chk("rnd_progress", consumed > 200, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that owns the PC and drives the IF/ID pipeline register feeding the decode stage.
- Fetches from a variable-latency instruction memory using a req/ready handshake.
- Holds the decode input stable under stall, using a one-entry skid buffer.
- Applies branch redirects from the memory stage, flushes IF/ID on redirect, and discards stale responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request; held high until imem_ready
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  input  1  response valid for the current request; ignored when imem_req=0
imem_rdata  input  32  instruction word, valid when imem_ready=1
stall  input  1  decode cannot accept; hold IF/ID
redirect  input  1  taken branch; flush and refetch from redirect_pc
redirect_pc  input  32  branch target; bits [1:0] ignored and forced to 0
if_valid  output  1  IF/ID holds a real instruction
if_pc4  output  32  PC+4 of the instruction in IF/ID
if_instr  output  32  instruction in IF/ID
fetch_busy  output  1  high in REQ or DRAIN

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, tgt=0, state=IDLE.
  - imem_req=0, if_valid=0, if_pc4=0, if_instr=32'h0000_0000 (NOP).
  - skid empty.
- All outputs are registered. imem_addr={pc[31:2],2'b00}. imem_req=1 exactly in states REQ and DRAIN.
- A transaction completes on a rising edge where imem_req&&imem_ready. At most one request is outstanding.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Default IF/ID update on each edge with stall=0 and no redirect: if no word is delivered that cycle, if_valid<=0 (bubble); if_pc4 and if_instr keep their values.
- State IDLE: next edge goes to REQ. Only reachable via reset.
- State REQ, transaction completes, no redirect:
  - If stall=0 or if_valid=0: if_instr<=imem_rdata, if_pc4<=pc+4, if_valid<=1. Then pc<=pc+4 and stay in REQ, so back-to-back fetches issue with no idle cycle.
  - If stall=1 and if_valid=1: skid<={imem_rdata,pc+4}, pc<=pc+4, go to FULL.
- State REQ, no completion: hold pc; IF/ID follows the stall/bubble rules above.
- State FULL (imem_req=0): when stall=0, IF/ID<=skid, if_valid<=1, skid emptied, go to REQ. While stall=1, hold everything.
- Redirect has the highest priority and overrides stall. On any edge with redirect=1: if_valid<=0 and skid emptied. Then, by state:
  - REQ with completion on the same edge: discard the returned word, pc<=redirect_pc, stay in REQ. The new address is presented on the next cycle.
  - REQ without completion: tgt<=redirect_pc, go to DRAIN. imem_addr stays unchanged so the bus protocol is respected.
  - DRAIN: tgt<=redirect_pc (the latest redirect wins).
  - FULL: pc<=redirect_pc, go to REQ.
  - IDLE: pc<=redirect_pc.
- State DRAIN (no redirect): on completion, discard the word, pc<=tgt, go to REQ. The IF/ID register never receives a drained word.
- stall with if_valid=0 does not block loading, because an empty slot is always fillable.
- Reset mid-transaction forces IDLE immediately. A late imem_ready is ignored because imem_req=0.

Test Plan:
- Straight-line fetch: RESET_PC=0, imem_ready=1 every cycle.
  -> imem_addr 0,4,8,... on consecutive cycles; if_pc4 4,8,12 one cycle later with if_valid=1 continuously.
- Latency 3: imem_ready pulses every third cycle.
  -> imem_addr stays 0x0 for 3 cycles; if_valid high one cycle per word with bubbles between; fetch_busy=1 throughout.
- Stall with full pipe: stall=1 for 4 cycles while 0x10 and 0x14 arrive.
  -> IF/ID holds instruction 0x10 (if_pc4=0x14); 0x14 goes to skid, state FULL, imem_req=0.
  -> stall=0 delivers 0x14 (if_pc4=0x18), then the fetch of 0x18 issues.
- Redirect during outstanding fetch: request to 0x20 pending, redirect=1 with redirect_pc=0x100, ready arrives 2 cycles later with 0xDEADBEEF.
  -> if_valid=0 and the word is never visible; next imem_addr=0x100.
- Redirect coincident with ready while stall=1: redirect_pc=0x203.
  -> IF/ID flushed, skid empty, next imem_addr=0x200.
- Async reset during DRAIN: pc returns to RESET_PC=0x40, imem_req=0, if_valid=0 before the next edge; a later imem_ready=1 causes no change; fetch resumes at 0x40.
- Wrap: pc=0xFFFF_FFFC with ready=1 -> if_pc4=0x0 and next imem_addr=0x0.
